multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Multicycle MIPS control FSM: the initiator on the ALU's control/flag interface. Sequences each
//   instruction through fetch/decode/execute/memory/writeback, drives alu_control_signal and datapath
//   mux/write-enables, consumes alu_zero for beq. Sits between the instruction register and the
//   shared datapath (ALU, regfile, unified memory, PC).
// PARAMETERS
//   ALU_CTRL_W   4   width of alu_control_signal
//   FLAG_ILLEGAL 1   1 = pulse illegal_instr on unknown opcode/funct; 0 = tie illegal_instr low
// PORTS
//   clk                 in   1  rising-edge clock
//   rst_n               in   1  asynchronous active-low reset
//   opcode              in   6  IR[31:26], stable from DECODE to end of instruction
//   funct               in   6  IR[5:0]
//   alu_zero            in   1  ALU result==0 flag (combinational from ALU)
//   alu_control_signal  out  4  ALU op code: 0000 AND,0001 OR,0010 ADD,0110 SUB,0111 SLT,1100 NOR
//   alu_src_a           out  1  0=PC, 1=reg A
//   alu_src_b           out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//   imm_zext            out  1  1 = zero-extend imm (andi/ori)
//   pc_src              out  2  00=ALU result, 01=ALUOut, 10=jump target
//   pc_write_en         out  1  pc_write | (branch & alu_zero)
//   iord                out  1  0=mem addr from PC, 1=from ALUOut
//   mem_read/mem_write  out  1  memory strobes
//   ir_write            out  1  latch instruction register
//   reg_dst             out  1  0=rt, 1=rd
//   mem_to_reg          out  1  0=ALUOut, 1=MDR
//   reg_write           out  1  regfile write enable
//   instr_done          out  1  1-cycle pulse in last state of each instruction
//   illegal_instr       out  1  1-cycle pulse; instruction abandoned, returns to FETCH
// BEHAVIOUR
//   - Moore FSM; outputs decoded from state (plus opcode/funct for ALU code). rst_n low: state=FETCH,
//     ALL write enables/strobes/pulses forced 0, alu_control_signal=0010, other selects 0. Reset
//     mid-instruction abandons it; first cycle after release is FETCH.
//   - States/transitions:
//     FETCH   mem_read,ir_write,src_a=0,src_b=01,ADD,pc_src=00,pc_write -> DECODE
//     DECODE  src_a=0,src_b=11,ADD (branch target to ALUOut); opcode dispatch:
//             100011/101011->MEMADR, 000000->RTYPE, 000100->BRANCH, 000010->JUMP,
//             001000/001100/001101/001010->IEXEC, other->FETCH + illegal_instr
//     MEMADR  src_a=1,src_b=10,ADD -> MEMRD (lw) | MEMWR (sw)
//     MEMRD   iord=1,mem_read -> MEMWB;  MEMWB reg_dst=0,mem_to_reg=1,reg_write,done -> FETCH
//     MEMWR   iord=1,mem_write,done -> FETCH
//     RTYPE   src_a=1,src_b=00, code from funct: 100000 ADD,100010 SUB,100100 AND,100101 OR,
//             101010 SLT,100111 NOR; unknown funct -> FETCH + illegal_instr, no writeback
//     RWB     reg_dst=1,mem_to_reg=0,reg_write,done -> FETCH
//     BRANCH  src_a=1,src_b=00,SUB,pc_src=01,branch; pc_write_en=alu_zero same cycle, done -> FETCH
//     IEXEC   src_a=1,src_b=10; addi ADD, andi AND+imm_zext, ori OR+imm_zext, slti SLT -> IWB
//     IWB     reg_dst=0,mem_to_reg=0,reg_write,done; imm_zext/ALU code held from IEXEC -> FETCH
//     JUMP    pc_src=10,pc_write,done -> FETCH
//   - Latency (cycles incl. FETCH): lw 5, sw 4, R 4, I-ALU 4, beq 3, j 3. Back-to-back, no idle.
//   - Unused/illegal state encodings recover to FETCH next cycle, no strobes asserted.
//   - alu_zero sampled only in BRANCH; ignored elsewhere. No two write strobes
//     (mem_write, reg_write, ir_write) ever high in the same cycle.
// STRUCTURE
//   - Package mips_ctrl_pkg: state_t enum, opcode/funct localparams, alu_ctrl_t codes (shared with
//     the ALU), alu_src_b/pc_src select encodings.
//   - Sub-module alu_decoder: combinational {state class, opcode, funct} -> alu_control_signal,
//     imm_zext, funct_illegal. FSM + output decode stay in multicycle_ctrl.
// TESTING
//   - rst_n low mid-MEMRD -> all strobes 0 immediately; after release FETCH: ir_write=1,pc_write_en=1.
//   - lw (100011) -> states F,D,MEMADR,MEMRD,MEMWB; reg_write+mem_to_reg=1 in cycle 5, done pulse.
//   - R sub (funct 100010) -> alu_control_signal=0110 in RTYPE, reg_dst=1 reg_write in RWB.
//   - beq with alu_zero=1 -> pc_write_en=1,pc_src=01 cycle 3; with alu_zero=0 -> pc_write_en=0.
//   - ori (001101) -> IEXEC code 0001, imm_zext=1; slti -> 0111; j -> pc_src=10 in cycle 3.
//   - opcode 111111 -> illegal_instr pulse in DECODE, next FETCH; R funct 000000 -> pulse, no reg_write.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
// ALU operation codes are shared with the ALU itself.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTYPE  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_t;

    // How the ALU code is chosen in a given state.
    typedef enum logic [1:0] {
        CLS_ADD   = 2'b00,
        CLS_SUB   = 2'b01,
        CLS_FUNCT = 2'b10,
        CLS_IMM   = 2'b11
    } alu_class_t;

    function automatic logic opcode_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU code decode from the controller's state class,
// the instruction opcode and the R-type funct field.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 4
) (
    input  alu_class_t            alu_class,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    output logic [ALU_CTRL_W-1:0] alu_control_signal,
    output logic                  imm_zext,
    output logic                  funct_illegal
);

    alu_ctrl_t code;

    always_comb begin
        code          = ALU_ADD;
        imm_zext      = 1'b0;
        funct_illegal = 1'b0;
        case (alu_class)
            CLS_ADD: code = ALU_ADD;
            CLS_SUB: code = ALU_SUB;
            CLS_FUNCT: begin
                case (funct)
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    FN_SLT:  code = ALU_SLT;
                    FN_NOR:  code = ALU_NOR;
                    default: funct_illegal = 1'b1;
                endcase
            end
            CLS_IMM: begin
                case (opcode)
                    OP_ANDI: begin code = ALU_AND; imm_zext = 1'b1; end
                    OP_ORI:  begin code = ALU_OR;  imm_zext = 1'b1; end
                    OP_SLTI: code = ALU_SLT;
                    default: code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control_signal = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, strobes and the ALU operation code.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W   = 4,
    parameter bit          FLAG_ILLEGAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  alu_zero,
    output logic [ALU_CTRL_W-1:0] alu_control_signal,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic                  imm_zext,
    output logic [1:0]            pc_src,
    output logic                  pc_write_en,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  instr_done,
    output logic                  illegal_instr
);

    state_t     state, next_state;
    alu_class_t alu_class;
    logic       pc_write, branch, funct_illegal, bad_instr;

    alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
        .alu_class          (alu_class),
        .opcode             (opcode),
        .funct              (funct),
        .alu_control_signal (alu_control_signal),
        .imm_zext           (imm_zext),
        .funct_illegal      (funct_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                      next_state = S_MEMADR;
                    OP_RTYPE:                          next_state = S_RTYPE;
                    OP_BEQ:                            next_state = S_BRANCH;
                    OP_J:                              next_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_IEXEC;
                    default:                           next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = S_MEMWB;
            S_RTYPE:  next_state = funct_illegal ? S_FETCH : S_RWB;
            S_IEXEC:  next_state = S_IWB;
            default:  next_state = S_FETCH;
        endcase
    end

    // Outputs are held inert while rst_n is low, not just after the state resets.
    always_comb begin
        alu_class  = CLS_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        bad_instr  = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    bad_instr = !opcode_legal(opcode);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    iord       = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_RTYPE: begin
                    alu_src_a = 1'b1;
                    alu_class = CLS_FUNCT;
                    bad_instr = funct_illegal;
                end
                S_RWB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_class  = CLS_SUB;
                    pc_src     = PCSRC_ALUOUT;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_class = CLS_IMM;
                end
                S_IWB: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    alu_class  = CLS_IMM;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = PCSRC_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pc_write_en   = pc_write | (branch & alu_zero);
    assign illegal_instr = FLAG_ILLEGAL & bad_instr;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its states and checks strobes, selects and ALU codes against hand values.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       alu_zero;
    logic [3:0] alu_control_signal;
    logic       alu_src_a, imm_zext, pc_write_en, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal_instr;
    logic [1:0] alu_src_b, pc_src;
    logic [6:0] strb;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    multicycle_ctrl #(.ALU_CTRL_W(4), .FLAG_ILLEGAL(1'b1)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .opcode             (opcode),
        .funct              (funct),
        .alu_zero           (alu_zero),
        .alu_control_signal (alu_control_signal),
        .alu_src_a          (alu_src_a),
        .alu_src_b          (alu_src_b),
        .imm_zext           (imm_zext),
        .pc_src             (pc_src),
        .pc_write_en        (pc_write_en),
        .iord               (iord),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .ir_write           (ir_write),
        .reg_dst            (reg_dst),
        .mem_to_reg         (mem_to_reg),
        .reg_write          (reg_write),
        .instr_done         (instr_done),
        .illegal_instr      (illegal_instr)
    );

    always #5 clk = ~clk;

    // {mem_read, mem_write, ir_write, reg_write, pc_write_en, instr_done, illegal_instr}
    assign strb = {mem_read, mem_write, ir_write, reg_write, pc_write_en, instr_done, illegal_instr};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        opcode   = 6'b100011;
        funct    = 6'b000000;
        alu_zero = 1'b0;

        // Reset held: everything inert, ALU code ADD
        #3;
        chk("rst_strobes", 8'(strb), 8'b0000000);
        chk("rst_alu", 8'(alu_control_signal), 8'h2);
        chk("rst_srcb", 8'(alu_src_b), 8'h0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("fetch0_strobes", 8'(strb), 8'b1010100);
        chk("fetch0_srcb", 8'(alu_src_b), 8'h1);

        // lw: F D MEMADR MEMRD MEMWB
        tick(); chk("lw_dec_strobes", 8'(strb), 8'b0000000);
                chk("lw_dec_srcb", 8'(alu_src_b), 8'h3);
        tick(); chk("lw_adr_srca", 8'(alu_src_a), 8'h1);
                chk("lw_adr_srcb", 8'(alu_src_b), 8'h2);
        tick(); chk("lw_rd_strobes", 8'(strb), 8'b1000000);
                chk("lw_rd_iord", 8'(iord), 8'h1);
        tick(); chk("lw_wb_strobes", 8'(strb), 8'b0001010);
                chk("lw_wb_m2r", 8'(mem_to_reg), 8'h1);
                chk("lw_wb_regdst", 8'(reg_dst), 8'h0);

        // sw: F D MEMADR MEMWR
        tick(); chk("sw_fetch", 8'(strb), 8'b1010100);
        opcode = 6'b101011;
        tick(); tick();
        tick(); chk("sw_wr_strobes", 8'(strb), 8'b0100010);
                chk("sw_wr_iord", 8'(iord), 8'h1);

        // R-type sub
        tick(); chk("sub_fetch", 8'(strb), 8'b1010100);
        opcode = 6'b000000; funct = 6'b100010;
        tick();
        tick(); chk("sub_rtype_alu", 8'(alu_control_signal), 8'h6);
                chk("sub_rtype_srcb", 8'(alu_src_b), 8'h0);
                chk("sub_rtype_strobes", 8'(strb), 8'b0000000);
        tick(); chk("sub_rwb_strobes", 8'(strb), 8'b0001010);
                chk("sub_rwb_regdst", 8'(reg_dst), 8'h1);

        // beq taken
        tick(); opcode = 6'b000100; alu_zero = 1'b1;
        tick(); chk("beq_dec_strobes", 8'(strb), 8'b0000000);
        tick(); chk("beq_t_strobes", 8'(strb), 8'b0000110);
                chk("beq_t_pcsrc", 8'(pc_src), 8'h1);
                chk("beq_t_alu", 8'(alu_control_signal), 8'h6);

        // beq not taken
        tick(); chk("beq2_fetch", 8'(strb), 8'b1010100);
        alu_zero = 1'b0;
        tick();
        tick(); chk("beq_nt_strobes", 8'(strb), 8'b0000010);

        // ori: OR with zero-extend, held into IWB
        tick(); opcode = 6'b001101; alu_zero = 1'b1;
        tick();
        tick(); chk("ori_ex_alu", 8'(alu_control_signal), 8'h1);
                chk("ori_ex_zext", 8'(imm_zext), 8'h1);
                chk("ori_ex_strobes", 8'(strb), 8'b0000000);
        tick(); chk("ori_wb_strobes", 8'(strb), 8'b0001010);
                chk("ori_wb_alu", 8'(alu_control_signal), 8'h1);
                chk("ori_wb_zext", 8'(imm_zext), 8'h1);

        // slti: SLT, sign-extended
        tick(); opcode = 6'b001010;
        tick();
        tick(); chk("slti_ex_alu", 8'(alu_control_signal), 8'h7);
                chk("slti_ex_zext", 8'(imm_zext), 8'h0);
        tick(); chk("slti_wb_strobes", 8'(strb), 8'b0001010);

        // andi: AND with zero-extend
        tick(); opcode = 6'b001100;
        tick();
        tick(); chk("andi_ex_alu", 8'(alu_control_signal), 8'h0);
                chk("andi_ex_zext", 8'(imm_zext), 8'h1);
        tick();

        // j
        tick(); opcode = 6'b000010;
        tick();
        tick(); chk("j_strobes", 8'(strb), 8'b0000110);
                chk("j_pcsrc", 8'(pc_src), 8'h2);

        // illegal opcode: pulse in DECODE, then FETCH
        tick(); opcode = 6'b111111;
        tick(); chk("badop_dec", 8'(strb), 8'b0000001);
        tick(); chk("badop_refetch", 8'(strb), 8'b1010100);

        // illegal funct: pulse in RTYPE, no writeback
        opcode = 6'b000000; funct = 6'b000000;
        tick();
        tick(); chk("badfn_rtype", 8'(strb), 8'b0000001);
        tick(); chk("badfn_refetch", 8'(strb), 8'b1010100);

        // R-type nor, back to back
        funct = 6'b100111;
        tick();
        tick(); chk("nor_alu", 8'(alu_control_signal), 8'hC);
        tick(); chk("nor_rwb", 8'(strb), 8'b0001010);

        // Reset during MEMRD
        tick(); opcode = 6'b100011;
        tick(); tick();
        tick(); chk("lw2_rd_strobes", 8'(strb), 8'b1000000);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_strobes", 8'(strb), 8'b0000000);
        chk("midrst_alu", 8'(alu_control_signal), 8'h2);
        chk("midrst_iord", 8'(iord), 8'h0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("postrst_fetch", 8'(strb), 8'b1010100);
        tick(); chk("postrst_dec", 8'(alu_src_b), 8'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
